vga_timing_receiver: RTL and testbench

Sink-side counterpart of the VGA sync generator. It samples h_sync / v_sync / blank_n (video_en) on the pixel clock, recovers per-pixel x/y coordinates, and measures line length and frame height. It declares lock after consecutive identical frames and flags timing errors. It sits in front of frame-capture and self-check logic.

---
 rtl/vga_timing_receiver.sv | 236 +++++++++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_receiver.sv
// VGA sink: recovers pixel x/y, measures line/frame totals, locks on stable timing.
// Define VGA_RX_GLITCH_FILTER_EN to add a 3-sample deglitch on all three inputs.
module vga_timing_receiver #(
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 2048
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        h_sync_i,
  input  logic        v_sync_i,
  input  logic        video_en_i,
  output logic        pixel_valid_o,
  output logic [9:0]  pixel_x_o,
  output logic [9:0]  pixel_y_o,
  output logic        line_start_o,
  output logic        frame_start_o,
  output logic        locked_o,
  output logic [10:0] h_total_o,
  output logic [10:0] v_total_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_e;

  logic [2:0] raw;
  logic [2:0] s0_d, s0_q, s1_q;

  assign raw = {h_sync_i, v_sync_i, video_en_i};

`ifdef VGA_RX_GLITCH_FILTER_EN
  logic [2:0] g0_q, g1_q;
  logic [2:0] agree;

  // A level is accepted only once three consecutive samples agree.
  always_comb begin
    agree = ~(raw ^ g0_q) & ~(raw ^ g1_q);
    s0_d  = (agree & raw) | (~agree & s0_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      g0_q <= '0;
      g1_q <= '0;
    end else begin
      g0_q <= raw;
      g1_q <= g0_q;
    end
  end
`else
  always_comb s0_d = raw;
`endif

  state_e      state_d, state_q;
  logic [10:0] h_cnt_d, h_cnt_q;
  logic [10:0] line_cnt_d, line_cnt_q;
  logic [10:0] ref_d, ref_q;
  logic        ref_vld_d, ref_vld_q;
  logic        stable_d, stable_q;
  logic [10:0] stor_h_d, stor_h_q;
  logic [10:0] stor_v_d, stor_v_q;
  logic [3:0]  match_d, match_q;
  logic [10:0] h_total_d, h_total_q;
  logic [10:0] v_total_d, v_total_q;
  logic [9:0]  x_cnt_d, x_cnt_q;
  logic [9:0]  y_cnt_d, y_cnt_q;
  logic        pv_d, pv_q;
  logic [9:0]  px_d, px_q;
  logic [9:0]  py_d, py_q;
  logic        ls_d, ls_q;
  logic        fs_d, fs_q;
  logic        err_d, err_q;

  logic        hs_fall, vs_fall, de, de_fall;
  logic [10:0] line_meas, frame_meas;
  logic [10:0] eff_ref;
  logic        eff_stable, eff_ref_vld;
  logic        frame_match, timeout, lock_now;

  assign hs_fall = s1_q[2] & ~s0_q[2];
  assign vs_fall = s1_q[1] & ~s0_q[1];
  assign de      = s0_q[0];
  assign de_fall = s1_q[0] & ~s0_q[0];

  assign line_meas  = (&h_cnt_q) ? h_cnt_q : h_cnt_q + 11'd1;
  assign frame_meas = line_cnt_q + {10'd0, hs_fall};

  // The closing hs_fall still belongs to the frame being judged.
  assign eff_stable  = stable_q &
                       ~(hs_fall & ref_vld_q & (line_meas != ref_q));
  assign eff_ref     = (~ref_vld_q & hs_fall) ? line_meas : ref_q;
  assign eff_ref_vld = ref_vld_q | hs_fall;
  assign frame_match = eff_stable & eff_ref_vld &
                       (eff_ref == stor_h_q) & (frame_meas == stor_v_q);

  assign timeout  = ~hs_fall & (int'(h_cnt_q) + 1 == TIMEOUT);
  assign lock_now = (state_q == LOCKED);

  always_comb begin
    h_cnt_d    = hs_fall ? 11'd0 :
                 (&h_cnt_q) ? h_cnt_q : h_cnt_q + 11'd1;
    line_cnt_d = vs_fall ? 11'd0 : frame_meas;
    ref_d      = ref_q;
    ref_vld_d  = ref_vld_q;
    stable_d   = stable_q;
    if (vs_fall) begin
      ref_d     = '0;
      ref_vld_d = 1'b0;
      stable_d  = 1'b1;
    end else if (hs_fall) begin
      ref_d     = eff_ref;
      ref_vld_d = 1'b1;
      stable_d  = eff_stable;
    end
  end

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    stor_h_d  = stor_h_q;
    stor_v_d  = stor_v_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vs_fall) begin
          state_d  = ACQUIRE;
          match_d  = '0;
          stor_h_d = '0;
          stor_v_d = '0;
        end
      end
      ACQUIRE: begin
        if (vs_fall) begin
          if (frame_match) begin
            match_d = match_q + 4'd1;
            if (int'(match_q) + 1 == LOCK_FRAMES) begin
              state_d   = LOCKED;
              h_total_d = stor_h_q;
              v_total_d = stor_v_q;
            end
          end else begin
            stor_h_d = eff_ref;
            stor_v_d = frame_meas;
            match_d  = '0;
          end
        end
      end
      LOCKED: begin
        if ((hs_fall && line_meas != h_total_q) ||
            (vs_fall && frame_meas != v_total_q)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      err_d   = (state_q != IDLE);
      state_d = IDLE;
    end
  end

  always_comb begin
    x_cnt_d = de ? x_cnt_q + 10'd1 : 10'd0;
    y_cnt_d = vs_fall ? 10'd0 : y_cnt_q + {9'd0, de_fall};
    pv_d    = lock_now & de;
    px_d    = !lock_now ? 10'd0 : de ? x_cnt_q : px_q;
    py_d    = !lock_now ? 10'd0 : de ? y_cnt_q : py_q;
    ls_d    = hs_fall;
    fs_d    = vs_fall;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s0_q       <= '0;
      s1_q       <= '0;
      state_q    <= IDLE;
      h_cnt_q    <= '0;
      line_cnt_q <= '0;
      ref_q      <= '0;
      ref_vld_q  <= 1'b0;
      stable_q   <= 1'b0;
      stor_h_q   <= '0;
      stor_v_q   <= '0;
      match_q    <= '0;
      h_total_q  <= '0;
      v_total_q  <= '0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      pv_q       <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      ls_q       <= 1'b0;
      fs_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s0_q;
      state_q    <= state_d;
      h_cnt_q    <= h_cnt_d;
      line_cnt_q <= line_cnt_d;
      ref_q      <= ref_d;
      ref_vld_q  <= ref_vld_d;
      stable_q   <= stable_d;
      stor_h_q   <= stor_h_d;
      stor_v_q   <= stor_v_d;
      match_q    <= match_d;
      h_total_q  <= h_total_d;
      v_total_q  <= v_total_d;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      pv_q       <= pv_d;
      px_q       <= px_d;
      py_q       <= py_d;
      ls_q       <= ls_d;
      fs_q       <= fs_d;
      err_q      <= err_d;
    end
  end

  assign pixel_valid_o = pv_q;
  assign pixel_x_o     = px_q;
  assign pixel_y_o     = py_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;
  assign locked_o      = lock_now;
  assign h_total_o     = h_total_q;
  assign v_total_o     = v_total_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver: 28x13 toy timing, lock, coords, errors.
module tb_vga_timing_receiver;
`ifdef VGA_RX_GLITCH_FILTER_EN
  localparam int LAT  = 4;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        h_sync_i = 1'b1;
  logic        v_sync_i = 1'b1;
  logic        video_en_i = 1'b0;
  logic        pixel_valid_o;
  logic [9:0]  pixel_x_o;
  logic [9:0]  pixel_y_o;
  logic        line_start_o;
  logic        frame_start_o;
  logic        locked_o;
  logic [10:0] h_total_o;
  logic [10:0] v_total_o;
  logic        err_o;

  always #5 clk = ~clk;

  vga_timing_receiver #(
    .LOCK_FRAMES(2),
    .TIMEOUT(100)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .h_sync_i(h_sync_i),
    .v_sync_i(v_sync_i),
    .video_en_i(video_en_i),
    .pixel_valid_o(pixel_valid_o),
    .pixel_x_o(pixel_x_o),
    .pixel_y_o(pixel_y_o),
    .line_start_o(line_start_o),
    .frame_start_o(frame_start_o),
    .locked_o(locked_o),
    .h_total_o(h_total_o),
    .v_total_o(v_total_o),
    .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  bit chk_en = 1'b0;
  bit hp = 1'b1;
  bit vp = 1'b1;
  bit lk_prev = 1'b0;
  int vs_cnt = 0;
  int vs_cyc[64];
  int hsf_cyc[13];
  int lock_rise = -1;
  int err_pulses = 0;
  int err_cyc = -1;
  int ls_bad = 0;
  int fs_bad = 0;
  int pv_bad = 0;
  int co_bad = 0;
  int rst_bad = 0;
  int valid_n = 0;
  int first_x = -1;
  int first_y = -1;
  int last_x = -1;
  int last_y = -1;
  int vb = 0;
  bit hf_h[8];
  bit vf_h[8];
  bit de_h[8];
  logic [9:0] px_h[8];
  logic [9:0] py_h[8];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // One pixel clock: drive inputs, then observe registered outputs.
  task automatic cyc(input bit h, input bit v, input bit d,
                     input int hx, input int ly, input bit glitch);
    bit hf;
    bit vf;
    @(posedge clk);
    #1;
    h_sync_i   = h;
    v_sync_i   = v;
    video_en_i = d;
    cyc_n++;
    hf = hp & ~h & ~(FILT & glitch);
    vf = vp & ~v;
    hp = h;
    vp = v;
    for (int k = 7; k > 0; k--) begin
      hf_h[k] = hf_h[k-1];
      vf_h[k] = vf_h[k-1];
      de_h[k] = de_h[k-1];
      px_h[k] = px_h[k-1];
      py_h[k] = py_h[k-1];
    end
    hf_h[0] = hf;
    vf_h[0] = vf;
    de_h[0] = d;
    px_h[0] = 10'(hx);
    py_h[0] = 10'(ly);
    if (hf && ly >= 0 && ly < 13) hsf_cyc[ly] = cyc_n;
    if (vf) begin
      vs_cnt++;
      if (vs_cnt < 64) vs_cyc[vs_cnt] = cyc_n;
    end
    if (!rst_ni && locked_o !== 1'b0) rst_bad++;
    if (locked_o && !lk_prev) lock_rise = cyc_n;
    if (err_o) begin
      err_pulses++;
      err_cyc = cyc_n;
    end
    if (chk_en) begin
      if (line_start_o !== hf_h[LAT]) ls_bad++;
      if (frame_start_o !== vf_h[LAT]) fs_bad++;
      if (locked_o && lk_prev && pixel_valid_o !== de_h[LAT]) pv_bad++;
      if (pixel_valid_o) begin
        if (valid_n == 0) begin
          first_x = int'(pixel_x_o);
          first_y = int'(pixel_y_o);
        end
        last_x = int'(pixel_x_o);
        last_y = int'(pixel_y_o);
        valid_n++;
        if (pixel_x_o !== px_h[LAT] || pixel_y_o !== py_h[LAT]) co_bad++;
      end
    end
    lk_prev = locked_o;
  endtask

  // 28 clk: 16 active, 4 front, 4 sync, 4 back (+extra in back porch).
  task automatic line(input int ly, input int extra, input int spike);
    for (int hx = 0; hx < 28 + extra; hx++) begin
      bit hs;
      hs = !(hx >= 20 && hx < 24) && (hx != spike);
      cyc(hs, ly != 10, (hx < 16) && (ly < 8), hx, ly, hx == spike);
    end
  endtask

  // 13 lines: 8 active, 2 front, 1 sync, 2 back.
  task automatic frame(input int gl, input int sl);
    for (int ly = 0; ly < 13; ly++)
      line(ly, (ly == gl) ? 1 : 0, (ly == sl) ? 8 : -1);
  endtask

  initial begin
    for (int i = 0; i < 5; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 1'b0);
    check("rst_locked_hold", rst_bad, 0);
    check("rst_locked", locked_o, 0);
    check("rst_valid", pixel_valid_o, 0);
    check("rst_x", pixel_x_o, 0);
    check("rst_y", pixel_y_o, 0);
    check("rst_line_start", line_start_o, 0);
    check("rst_frame_start", frame_start_o, 0);
    check("rst_h_total", h_total_o, 0);
    check("rst_v_total", v_total_o, 0);
    check("rst_err", err_o, 0);

    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 0, 15, 1'b0);
    chk_en = 1'b1;
    vs_cnt = 0;
    err_pulses = 0;
    lock_rise = -1;

    repeat (4) frame(-1, -1);
    check("lock_time", lock_rise, vs_cyc[4] + LAT);
    check("lock_locked", locked_o, 1);
    check("lock_h_total", h_total_o, 28);
    check("lock_v_total", v_total_o, 13);
    check("lock_no_err", err_pulses, 0);

    valid_n = 0;
    co_bad = 0;
    frame(-1, -1);
    check("coord_count", valid_n, 128);
    check("coord_first_x", first_x, 0);
    check("coord_first_y", first_y, 0);
    check("coord_last_x", last_x, 15);
    check("coord_last_y", last_y, 7);
    check("coord_lag", co_bad, 0);

    err_pulses = 0;
    lock_rise = -1;
    vb = vs_cnt;
    frame(3, -1);
    check("glitch_err_n", err_pulses, 1);
    check("glitch_err_cyc", err_cyc, hsf_cyc[4] + LAT);
    check("glitch_unlock", locked_o, 0);
    check("glitch_h_kept", h_total_o, 28);
    repeat (3) frame(-1, -1);
    check("relock_time", lock_rise, vs_cyc[vb + 4] + LAT);
    check("relock_locked", locked_o, 1);

    err_pulses = 0;
    for (int i = 0; i < 120; i++) cyc(1'b1, 1'b1, 1'b0, 0, 15, 1'b0);
    check("timeout_err_n", err_pulses, 1);
    check("timeout_unlock", locked_o, 0);
    check("timeout_h_kept", h_total_o, 28);
    check("timeout_v_kept", v_total_o, 13);

    repeat (4) frame(-1, -1);
    check("relock2_locked", locked_o, 1);

    err_pulses = 0;
    frame(-1, 2);
    check("spike_err_n", err_pulses, FILT ? 0 : 1);
    check("spike_locked", locked_o, FILT ? 1 : 0);

    for (int ly = 0; ly < 6; ly++) line(ly, 0, -1);
    chk_en = 1'b0;
    rst_ni = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 0, 15, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 0, 15, 1'b0);
    check("midrst_locked", locked_o, 0);
    check("midrst_h_total", h_total_o, 0);
    check("midrst_v_total", v_total_o, 0);
    check("midrst_valid", pixel_valid_o, 0);
    rst_ni = 1'b1;

    check("line_start_track", ls_bad, 0);
    check("frame_start_track", fs_bad, 0);
    check("valid_track", pv_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
